// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage downstream of the opcode decoder. Performs one byte,
//   halfword or word access against a 32-bit little-endian, word-addressed
//   data memory using a req/ready handshake. Returns aligned, sign- or
//   zero-extended load data and a busy stall to the datapath.
//
//   Optional feature: define LSU_TIMEOUT_EN to abort an access after
//   TIMEOUT_CYC cycles without mem_ready (err_code 11). Without it, ACCESS
//   waits indefinitely.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start                 issue request (sampled only in IDLE)
//   mem_read, mem_write   load / store command
//   byte_sig, hw_sig      access size (byte has priority, else half, else word)
//   sign_sig              1 = sign-extend loads, 0 = zero-extend
//   addr, store_data      byte address, rt store value
//   mem_req/we/be/addr/wdata, mem_rdata, mem_ready   memory handshake
//   busy, done            stall to datapath, one-cycle completion pulse
//   load_data             extended load result (updated by successful loads only)
//   err, err_code         00 none, 01 misaligned, 10 illegal, 11 timeout

module load_store_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              byte_sig,
  input  logic              hw_sig,
  input  logic              sign_sig,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t            r_state;
  size_t             r_size;
  logic [1:0]        r_lane;
  logic              r_sign;
  logic              r_is_load;
  logic              r_req;
  logic              r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic [31:0]       r_load_data;
  logic              r_err;
  logic [1:0]        r_err_code;

  size_t             w_size;
  logic              w_illegal;
  logic              w_misalign;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] r_cnt;
`else
  // TIMEOUT_CYC only matters when the timeout is compiled in
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYC);
`endif

  // Request decode from the live decoder inputs
  always_comb begin
    w_size = SZ_WORD;
    if (byte_sig)    w_size = SZ_BYTE;
    else if (hw_sig) w_size = SZ_HALF;

    w_illegal  = (mem_read == mem_write);
    w_misalign = ((w_size == SZ_HALF) && addr[0]) ||
                 ((w_size == SZ_WORD) && (addr[1:0] != 2'b00));

    w_be    = 4'b1111;
    w_wdata = store_data;
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the lane/size latched at issue, not the live inputs
  always_comb begin
    w_byte = '0;
    w_half = '0;
    w_load = mem_rdata;
    case (r_size)
      SZ_BYTE: begin
        case (r_lane)
          2'd0:    w_byte = mem_rdata[7:0];
          2'd1:    w_byte = mem_rdata[15:8];
          2'd2:    w_byte = mem_rdata[23:16];
          default: w_byte = mem_rdata[31:24];
        endcase
        w_load = {{24{r_sign & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load = {{16{r_sign & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_size      <= SZ_WORD;
      r_lane      <= '0;
      r_sign      <= 1'b0;
      r_is_load   <= 1'b0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_load_data <= '0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
`ifdef LSU_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_illegal || w_misalign) begin
              // Error path skips the memory entirely; illegal outranks misaligned
              r_state    <= S_RESP;
              r_done     <= 1'b1;
              r_err      <= 1'b1;
              r_err_code <= w_illegal ? 2'b10 : 2'b01;
            end else begin
              r_state   <= S_ACCESS;
              r_req     <= 1'b1;
              r_we      <= mem_write;
              r_be      <= w_be;
              r_addr    <= {addr[ADDR_W-1:2], 2'b00};
              r_wdata   <= mem_write ? w_wdata : '0;
              r_size    <= w_size;
              r_lane    <= addr[1:0];
              r_sign    <= sign_sig;
              r_is_load <= mem_read;
`ifdef LSU_TIMEOUT_EN
              r_cnt     <= '0;
`endif
            end
          end
        end

        S_ACCESS: begin
          if (mem_ready) begin
            r_state <= S_RESP;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b1;
            if (r_is_load) r_load_data <= w_load;
          end
`ifdef LSU_TIMEOUT_EN
          // r_cnt counts completed waiting cycles; abort on the TIMEOUT_CYC-th
          else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_state    <= S_RESP;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
            r_err_code <= 2'b11;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end

        S_RESP: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_err      <= 1'b0;
          r_err_code <= '0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign load_data = r_load_data;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit. Outputs are sampled and inputs
// driven on the falling clock edge; the DUT acts on the rising edge.
// The timeout case follows LSU_TIMEOUT_EN (DUT built with TIMEOUT_CYC = 4).

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mem_read, mem_write, byte_sig, hw_sig, sign_sig;
  logic [31:0] addr, store_data;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        busy, done, err;
  logic [31:0] load_data;
  logic [1:0]  err_code;

  int n_chk = 0;
  int n_err = 0;

  // results gathered by run_access
  int          g_req_cycles, g_done_at, g_done_cnt;
  logic [3:0]  g_be;
  logic [31:0] g_addr, g_wdata, g_ld;
  logic        g_we, g_err;
  logic [1:0]  g_code;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_read(mem_read), .mem_write(mem_write),
    .byte_sig(byte_sig), .hw_sig(hw_sig), .sign_sig(sign_sig),
    .addr(addr), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .load_data(load_data),
    .err(err), .err_code(err_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a command with start=1; call just after a falling edge
  task automatic issue(input logic rd, input logic wr, input logic b, input logic h,
                       input logic s, input logic [31:0] a, input logic [31:0] d);
    start = 1'b1; mem_read = rd; mem_write = wr; byte_sig = b; hw_sig = h;
    sign_sig = s; addr = a; store_data = d;
  endtask

  // Run ncyc cycles after issue; mem_ready pulses in cycle ready_at (<0: never).
  // restart re-asserts start in cycles 2 and 3, while the DUT should be busy.
  task automatic run_access(input int ncyc, input int ready_at,
                            input logic [31:0] rdata, input logic restart);
    g_req_cycles = 0; g_done_at = -1; g_done_cnt = 0;
    g_be = '0; g_addr = '0; g_wdata = '0; g_we = 1'b0;
    g_ld = '0; g_err = 1'b0; g_code = '0;
    mem_rdata = rdata;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      start = restart && (i == 2 || i == 3);
      if (mem_req) begin
        if (g_req_cycles == 0) begin
          g_be = mem_be; g_addr = mem_addr; g_wdata = mem_wdata; g_we = mem_we;
        end
        g_req_cycles++;
      end
      if (done) begin
        g_done_cnt++;
        if (g_done_at < 0) begin
          g_done_at = i; g_err = err; g_code = err_code; g_ld = load_data;
        end
      end
      mem_ready = (i == ready_at);
    end
    start = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".req"},   32'(mem_req),   32'd0);
    chk({tag, ".busy"},  32'(busy),      32'd0);
    chk({tag, ".done"},  32'(done),      32'd0);
    chk({tag, ".be"},    32'(mem_be),    32'd0);
    chk({tag, ".addr"},  mem_addr,       32'd0);
    chk({tag, ".wdata"}, mem_wdata,      32'd0);
    chk({tag, ".we"},    32'(mem_we),    32'd0);
    chk({tag, ".ld"},    load_data,      32'd0);
    chk({tag, ".err"},   32'(err),       32'd0);
    chk({tag, ".code"},  32'(err_code),  32'd0);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    byte_sig = 1'b0; hw_sig = 1'b0; sign_sig = 1'b0; addr = '0;
    store_data = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    rst_n = 1'b1;

    // Reset while in ACCESS: request dropped, no done
    @(negedge clk);
    issue(1, 0, 0, 0, 0, 32'h10, 32'h0);
    @(negedge clk);
    start = 1'b0;
    chk("rst_acc.req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle_zero("rst_acc");
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || mem_req) dones++;
    end
    chk("rst_acc.quiet", 32'(dones), 32'd0);

    // Signed byte load, lane 3, ready immediately
    issue(1, 0, 1, 0, 1, 32'h1003, 32'h0);
    run_access(5, 1, 32'h80AABBCC, 1'b0);
    chk("lb.addr",  g_addr, 32'h1000);
    chk("lb.be",    32'(g_be), 32'h8);
    chk("lb.we",    32'(g_we), 32'd0);
    chk("lb.wdata", g_wdata, 32'd0);
    chk("lb.reqs",  32'(g_req_cycles), 32'd1);
    chk("lb.done_at", 32'(g_done_at), 32'd2);
    chk("lb.ndone", 32'(g_done_cnt), 32'd1);
    chk("lb.err",   32'(g_err), 32'd0);
    chk("lb.ld",    g_ld, 32'hFFFFFF80);
    chk("lb.busy_after", 32'(busy), 32'd0);

    // Halfword store with 3 wait cycles
    issue(0, 1, 0, 1, 0, 32'h2002, 32'h1234ABCD);
    run_access(8, 4, 32'h0, 1'b0);
    chk("sh.addr",  g_addr, 32'h2000);
    chk("sh.be",    32'(g_be), 32'hC);
    chk("sh.we",    32'(g_we), 32'd1);
    chk("sh.wdata", g_wdata, 32'hABCDABCD);
    chk("sh.reqs",  32'(g_req_cycles), 32'd4);
    chk("sh.done_at", 32'(g_done_at), 32'd5);
    chk("sh.err",   32'(g_err), 32'd0);
    chk("sh.ld_kept", load_data, 32'hFFFFFF80);

    // Misaligned word load
    issue(1, 0, 0, 0, 0, 32'h0006, 32'h0);
    run_access(4, -1, 32'h0, 1'b0);
    chk("mis.reqs", 32'(g_req_cycles), 32'd0);
    chk("mis.done_at", 32'(g_done_at), 32'd1);
    chk("mis.err",  32'(g_err), 32'd1);
    chk("mis.code", 32'(g_code), 32'd1);
    chk("mis.ld_kept", load_data, 32'hFFFFFF80);

    // Illegal: read and write together
    issue(1, 1, 1, 0, 0, 32'h0, 32'h0);
    run_access(4, -1, 32'h0, 1'b0);
    chk("ill.reqs", 32'(g_req_cycles), 32'd0);
    chk("ill.done_at", 32'(g_done_at), 32'd1);
    chk("ill.code", 32'(g_code), 32'd2);
    chk("ill.err_clr", 32'(err), 32'd0);

    // Neither read nor write, also misaligned: illegal wins
    issue(0, 0, 0, 0, 0, 32'h1, 32'h0);
    run_access(4, -1, 32'h0, 1'b0);
    chk("both.code", 32'(g_code), 32'd2);

    // Zero-extended halfword load, start re-pulsed while busy
    issue(1, 0, 0, 1, 0, 32'h0002, 32'h0);
    run_access(10, 2, 32'hF00D1234, 1'b1);
    chk("lhu.be",   32'(g_be), 32'hC);
    chk("lhu.reqs", 32'(g_req_cycles), 32'd2);
    chk("lhu.ndone", 32'(g_done_cnt), 32'd1);
    chk("lhu.done_at", 32'(g_done_at), 32'd3);
    chk("lhu.ld",   g_ld, 32'h0000F00D);

    // Signed halfword load, low lane
    issue(1, 0, 0, 1, 1, 32'h0000, 32'h0);
    run_access(5, 1, 32'hF00D8765, 1'b0);
    chk("lh.be", 32'(g_be), 32'h3);
    chk("lh.ld", g_ld, 32'hFFFF8765);

    // Zero-extended byte load, lane 1 (byte wins over hw_sig)
    issue(1, 0, 1, 1, 0, 32'h0005, 32'h0);
    run_access(5, 1, 32'h80AABBCC, 1'b0);
    chk("lbu.addr", g_addr, 32'h4);
    chk("lbu.be",   32'(g_be), 32'h2);
    chk("lbu.ld",   g_ld, 32'h000000BB);

    // Word load passes through
    issue(1, 0, 0, 0, 1, 32'h0008, 32'h0);
    run_access(5, 1, 32'h80AABBCC, 1'b0);
    chk("lw.be", 32'(g_be), 32'hF);
    chk("lw.ld", g_ld, 32'h80AABBCC);

    // Word store
    issue(0, 1, 0, 0, 0, 32'h000C, 32'hDEADBEEF);
    run_access(5, 1, 32'h0, 1'b0);
    chk("sw.be",    32'(g_be), 32'hF);
    chk("sw.wdata", g_wdata, 32'hDEADBEEF);
    chk("sw.ld_kept", load_data, 32'h80AABBCC);

    // Byte store, lane 1
    issue(0, 1, 1, 0, 0, 32'h0001, 32'h1234565A);
    run_access(5, 1, 32'h0, 1'b0);
    chk("sb.be",    32'(g_be), 32'h2);
    chk("sb.wdata", g_wdata, 32'h5A5A5A5A);

`ifdef LSU_TIMEOUT_EN
    // Memory never answers: abort after 4 ACCESS cycles
    issue(1, 0, 0, 0, 0, 32'h0010, 32'h0);
    run_access(8, -1, 32'h11111111, 1'b0);
    chk("to.reqs",    32'(g_req_cycles), 32'd4);
    chk("to.done_at", 32'(g_done_at), 32'd5);
    chk("to.err",     32'(g_err), 32'd1);
    chk("to.code",    32'(g_code), 32'd3);
    chk("to.ld_kept", load_data, 32'h80AABBCC);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("to.late_ready", 32'(done | mem_req), 32'd0);
`else
    // Memory never answers: request still pending after 1000 cycles
    issue(1, 0, 0, 0, 0, 32'h0010, 32'h0);
    run_access(1000, -1, 32'h11111111, 1'b0);
    chk("nto.req",  32'(mem_req), 32'd1);
    chk("nto.busy", 32'(busy), 32'd1);
    chk("nto.ndone", 32'(g_done_cnt), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("nto.req_rst", 32'(mem_req), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the opcode decoder. It consumes MemRead/MemWrite/HWsig/ByteSig/SignSig plus the ALU-computed address and rt data.
- Runs one byte, halfword or word access against a 32-bit little-endian, word-addressed data memory through a req/ready handshake.
- Returns aligned, sign- or zero-extended load data and a stall (busy) to the datapath.

Parameters:
- ADDR_W, 32, byte-address width
- TIMEOUT_CYC, 255, max cycles waiting for mem_ready; used only when the optional feature is compiled in

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  issue request; sampled only in IDLE
- mem_read  in  1  load command (decoder MemRead)
- mem_write  in  1  store command (decoder MemWrite)
- byte_sig  in  1  byte access (decoder ByteSig)
- hw_sig  in  1  halfword access (decoder HWsig)
- sign_sig  in  1  1 = sign-extend load, 0 = zero-extend (decoder SignSig)
- addr  in  ADDR_W  byte address
- store_data  in  32  rt value; low byte/half used for sub-word stores
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables, bit k = byte lane k
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_wdata  out  32  lane-replicated write data
- mem_rdata  in  32  read data, valid when mem_ready = 1
- mem_ready  in  1  completes the request in the cycle it is high with mem_req
- busy  out  1  stall to datapath
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result
- err  out  1  valid with done
- err_code  out  2  00 none, 01 misaligned, 10 illegal command, 11 timeout

Behaviour:
- Clocking and reset:
  - Single clock domain (clk).
  - rst_n is synchronous, active-low, applied at the clk edge, and aborts any access.
  - Reset values: state = IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy, done, load_data, err and err_code are all 0.
- Size decode:
  - byte_sig = 1 selects byte access, with priority over hw_sig.
  - Otherwise hw_sig = 1 selects halfword access.
  - Otherwise word access.
- Legality checks, made in IDLE on start:
  - mem_read and mem_write both 1, or both 0 → illegal command, code 10.
  - Halfword with addr[0] = 1, or word with addr[1:0] ≠ 0 → misaligned, code 01.
  - If both apply, illegal command takes precedence.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - start with a legal command → ACCESS. The mem_* outputs are registered on that edge, so mem_req = 1 from cycle N+1.
  - start with an illegal or misaligned command → RESP with no memory request.
  - No start → stay in IDLE.
- ACCESS:
  - mem_req, mem_we, mem_be, mem_addr and mem_wdata are held stable until mem_ready = 1.
  - On mem_ready: for loads, capture the extracted load_data; drop mem_req on the same edge; go to RESP.
- RESP:
  - done = 1 for exactly one cycle, with err and err_code valid.
  - Then go to IDLE. err and err_code clear on that return.
- busy = 1 whenever state ≠ IDLE. start while busy is ignored.
- Latency:
  - Legal access: done at N+1+W+1, where W ≥ 0 is the number of extra wait cycles; minimum 2 cycles after start.
  - Error: done at N+1.
- Store lane mapping:
  - Byte: mem_be = 1 << addr[1:0]; mem_wdata = {4{store_data[7:0]}}.
  - Halfword: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{store_data[15:0]}}.
  - Word: mem_be = 1111; mem_wdata = store_data.
- Load extraction:
  - Byte lane addr[1:0] or half lane addr[1], extended to 32 bits per sign_sig; word passes through.
  - Loads drive mem_be the same as stores; mem_wdata = 0 on loads.
- load_data holds its value across stores and errors; only successful loads update it.
- Reset asserted in ACCESS: mem_req = 0 after that edge, no done pulse.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter counts ACCESS cycles without mem_ready.
  - When the count reaches TIMEOUT_CYC: drop mem_req, go to RESP with err = 1, err_code = 11, load_data unchanged.
  - A late mem_ready after the abort is ignored.
- Undefined:
  - ACCESS waits indefinitely; code 11 is never produced; no counter logic is present.

Test Plan:
- Load signed byte: addr = 0x1003, mem_read = 1, byte_sig = 1, sign_sig = 1, mem_rdata = 0x80AABBCC, ready immediately → mem_addr = 0x1000, mem_be = 1000, load_data = 0xFFFFFF80, done 2 cycles after start, err = 0.
- Store halfword with 3 wait cycles: addr = 0x2002, store_data = 0x1234ABCD → mem_be = 1100, mem_wdata = 0xABCDABCD, mem_req held 4 cycles, done 5 cycles after start, load_data unchanged.
- Misaligned word load at addr = 0x0006 → no mem_req, done at N+1, err_code = 01. Illegal command (mem_read = mem_write = 1) → err_code = 10.
- Zero-extended halfword load: addr = 0x0002, mem_rdata = 0xF00D1234, sign_sig = 0 → load_data = 0x0000F00D. start pulsed while busy → ignored, exactly one mem_req transaction.
- rst_n = 0 for one cycle while in ACCESS → mem_req = 0 the next cycle, busy = 0, no done, all outputs 0.
- With LSU_TIMEOUT_EN and TIMEOUT_CYC = 4, mem_ready tied low → mem_req drops after 4 ACCESS cycles, done with err_code = 11. Without the macro → mem_req still high after 1000 cycles.
